buf_arbiter: RTL

BUF_ARBITER -- requirements
Module: buf_arbiter

---
 rtl/buf_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/buf_arbiter.sv
// buf_arbiter: two-requester arbiter for a single-ported pixel buffer memory.
// Requester A (filter write-back) and requester B (readout) share one port;
// a granted requester issues one beat per cycle while its req is high.
// Grants are released on a last beat, on the MAXBURST-th beat, or when the
// owner drops req; the other requester is then granted with no idle bubble.
// Optional feature macro: BUF_ARB_FIXED_PRIO_EN -- when defined, ties always
// go to A and the round-robin pointer is removed.
//
// Handshake: a beat occurs in every cycle where gnt_x is high and req_x is
// high; memory strobes/addresses/data are driven combinationally from the
// owner in that cycle, and a read beat is answered by rvalid_x exactly one
// cycle later.
module buf_arbiter #(
   parameter int BITS     = 8,
   parameter int ADDRLEN  = 21,
   parameter int MAXBURST = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_a,
   input  logic               req_b,
   input  logic               wr_a,
   input  logic               wr_b,
   input  logic [ADDRLEN-1:0] addr_a,
   input  logic [ADDRLEN-1:0] addr_b,
   input  logic [BITS-1:0]    wdata_a,
   input  logic [BITS-1:0]    wdata_b,
   input  logic               last_a,
   input  logic               last_b,
   output logic               gnt_a,
   output logic               gnt_b,
   output logic               rvalid_a,
   output logic               rvalid_b,
   output logic               ren,
   output logic               wen,
   output logic [ADDRLEN-1:0] raddr,
   output logic [ADDRLEN-1:0] waddr,
   output logic [BITS-1:0]    wdata,
   output logic [1:0]         state_o
);

   localparam int CW = $clog2(MAXBURST + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAXBURST);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GNT_A = 2'd1,
      S_GNT_B = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rvalid_a_q, rvalid_a_d;
   logic              rvalid_b_q, rvalid_b_d;
`ifndef BUF_ARB_FIXED_PRIO_EN
   // 1 when B was granted most recently, 0 when A was.
   logic              last_b_q, last_b_d;
`endif

   logic               own_req;
   logic               own_wr;
   logic               own_last;
   logic [ADDRLEN-1:0] own_addr;
   logic [BITS-1:0]    own_wdata;
   logic               beat;
   logic               rel;
   logic [CW-1:0]      beat_cnt;

   // Select the current owner's request signals.
   always_comb begin
      own_req   = 1'b0;
      own_wr    = 1'b0;
      own_last  = 1'b0;
      own_addr  = '0;
      own_wdata = '0;
      case (state_q)
         S_GNT_A: begin
            own_req   = req_a;
            own_wr    = wr_a;
            own_last  = last_a;
            own_addr  = addr_a;
            own_wdata = wdata_a;
         end
         S_GNT_B: begin
            own_req   = req_b;
            own_wr    = wr_b;
            own_last  = last_b;
            own_addr  = addr_b;
            own_wdata = wdata_b;
         end
         default: ;
      endcase
   end

   assign beat     = own_req;
   assign beat_cnt = cnt_q + 1'b1;

   assign ren      = beat & ~own_wr;
   assign wen      = beat & own_wr;
   assign raddr    = own_addr;
   assign waddr    = own_addr;
   assign wdata    = own_wdata;

   assign gnt_a    = (state_q == S_GNT_A);
   assign gnt_b    = (state_q == S_GNT_B);
   assign rvalid_a = rvalid_a_q;
   assign rvalid_b = rvalid_b_q;
   assign state_o  = state_q;

   // Next-state, burst counter, release and tie-break decisions.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rel        = 1'b0;
      rvalid_a_d = ren && (state_q == S_GNT_A);
      rvalid_b_d = ren && (state_q == S_GNT_B);
`ifndef BUF_ARB_FIXED_PRIO_EN
      last_b_d   = last_b_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_a && req_b) begin
`ifdef BUF_ARB_FIXED_PRIO_EN
               state_d = S_GNT_A;
`else
               state_d = last_b_q ? S_GNT_A : S_GNT_B;
`endif
            end else if (req_a) begin
               state_d = S_GNT_A;
            end else if (req_b) begin
               state_d = S_GNT_B;
            end
         end
         default: begin
            if (!own_req || own_last || (beat_cnt == MAX_CNT)) begin
               rel = 1'b1;
            end else begin
               cnt_d = beat_cnt;
            end
            if (rel) begin
               cnt_d = '0;
`ifdef BUF_ARB_FIXED_PRIO_EN
               if (state_q == S_GNT_A) begin
                  state_d = req_b ? (req_a ? S_GNT_A : S_GNT_B) : S_IDLE;
               end else begin
                  state_d = req_a ? S_GNT_A : S_IDLE;
               end
`else
               if (state_q == S_GNT_A) begin
                  state_d = req_b ? S_GNT_B : S_IDLE;
               end else begin
                  state_d = req_a ? S_GNT_A : S_IDLE;
               end
`endif
            end
         end
      endcase
`ifndef BUF_ARB_FIXED_PRIO_EN
      if (state_d == S_GNT_A) begin
         last_b_d = 1'b0;
      end else if (state_d == S_GNT_B) begin
         last_b_d = 1'b1;
      end
`endif
   end

   // State, counter, pointer and read-valid registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
`ifndef BUF_ARB_FIXED_PRIO_EN
         last_b_q   <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
`ifndef BUF_ARB_FIXED_PRIO_EN
         last_b_q   <= last_b_d;
`endif
      end
   end

endmodule
